// File: rtl/iir_stream_ctrl_if.sv
// Sample-memory read, filter feed/return and result-write signals of iir_stream_ctrl.
// The controller is the master; the memories and the filter sit on the slave side.
interface iir_stream_ctrl_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 11
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;

  logic [DATA_W-1:0] iir_data_in;
  logic              iir_data_in_valid;
  logic              iir_pipeline_en;
  logic [DATA_W-1:0] iir_data_out;
  logic              iir_data_out_valid;
  logic              iir_stable;

  logic              out_wr_en;
  logic [ADDR_W-1:0] out_wr_addr;
  logic [DATA_W-1:0] out_wr_data;

  modport master (
    output mem_rd_en, mem_addr, iir_data_in, iir_data_in_valid,
           out_wr_en, out_wr_addr, out_wr_data,
    input  mem_rd_data, iir_pipeline_en, iir_data_out, iir_data_out_valid, iir_stable
  );

  modport slave (
    input  mem_rd_en, mem_addr, iir_data_in, iir_data_in_valid,
           out_wr_en, out_wr_addr, out_wr_data,
    output mem_rd_data, iir_pipeline_en, iir_data_out, iir_data_out_valid, iir_stable
  );
endinterface

// File: rtl/iir_stream_ctrl.sv
// Streams one frame from sample memory through an IIR filter and writes settled results back.
// Feed is 1 sample/cycle after iir_pipeline_en (1-cycle read latency); results are registered once; DRAIN times out.
module iir_stream_ctrl #(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 11,
  parameter int FRAME_LEN = 2048,
  parameter int TIMEOUT   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  iir_stream_ctrl_if.master bus,
  output logic              busy,
  output logic              filter_done,
  output logic              timeout_err
);

  typedef enum logic [2:0] {IDLE, WAIT_EN, FEED, DRAIN, DONE} state_e;

  // One extra counter bit so FRAME_LEN == 2**ADDR_W is representable.
  localparam int CNT_W  = ADDR_W + 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST_ADDR   = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  FRAME_CNT   = CNT_W'(FRAME_LEN);
  localparam logic [IDLE_W-1:0] TIMEOUT_CNT = IDLE_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic              in_vld_q, in_vld_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              feeding;
  logic              capture;

  assign feeding = (state_q == FEED);
  assign capture = !abort && (feeding || (state_q == DRAIN)) &&
                   bus.iir_data_out_valid && bus.iir_stable && (out_cnt_q < FRAME_CNT);

  always_comb begin
    state_d       = state_q;
    rd_cnt_d      = rd_cnt_q;
    out_cnt_d     = out_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    timeout_err_d = timeout_err_q;
    in_vld_d      = feeding && !abort;
    wr_en_d       = capture;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;

    if (capture) begin
      wr_addr_d = out_cnt_q[ADDR_W-1:0];
      wr_data_d = bus.iir_data_out;
      out_cnt_d = out_cnt_q + 1'b1;
    end

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d       = WAIT_EN;
            rd_cnt_d      = '0;
            out_cnt_d     = '0;
            idle_cnt_d    = '0;
            timeout_err_d = 1'b0;
          end
        end
        WAIT_EN: begin
          if (bus.iir_pipeline_en) state_d = FEED;
        end
        FEED: begin
          rd_cnt_d   = rd_cnt_q + 1'b1;
          idle_cnt_d = '0;
          if (rd_cnt_q == LAST_ADDR) state_d = DRAIN;
        end
        DRAIN: begin
          // Completion wins over a timeout landing on the same cycle.
          idle_cnt_d = capture ? '0 : idle_cnt_q + 1'b1;
          if (out_cnt_d == FRAME_CNT) begin
            state_d = DONE;
          end else if (idle_cnt_d == TIMEOUT_CNT) begin
            state_d       = DONE;
            timeout_err_d = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rd_cnt_q      <= '0;
      out_cnt_q     <= '0;
      idle_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      in_vld_q      <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      rd_cnt_q      <= rd_cnt_d;
      out_cnt_q     <= out_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      timeout_err_q <= timeout_err_d;
      in_vld_q      <= in_vld_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
    end
  end

  assign bus.mem_rd_en         = feeding;
  assign bus.mem_addr          = feeding ? rd_cnt_q[ADDR_W-1:0] : '0;
  assign bus.iir_data_in_valid = in_vld_q;
  assign bus.iir_data_in       = in_vld_q ? bus.mem_rd_data : '0;
  assign bus.out_wr_en         = wr_en_q;
  assign bus.out_wr_addr       = wr_addr_q;
  assign bus.out_wr_data       = wr_data_q;

  assign busy        = (state_q == WAIT_EN) || feeding || (state_q == DRAIN);
  assign filter_done = (state_q == DONE);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_iir_stream_ctrl.sv
// Bench for iir_stream_ctrl: random frame data and filter responses, checked against an expected-write model.
module tb_iir_stream_ctrl;
  localparam int DATA_W    = 24;
  localparam int ADDR_W    = 3;
  localparam int FRAME_LEN = 8;
  localparam int TIMEOUT   = 16;
  localparam int LAT       = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, filter_done, timeout_err;

  iir_stream_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  iir_stream_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_LEN(FRAME_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus),
    .busy(busy), .filter_done(filter_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic emit_busy = 1'b0;

  logic [DATA_W-1:0] mem [FRAME_LEN];
  int                rd_addr_q[$], rd_cyc_q[$], in_cyc_q[$], wr_addr_q[$], wr_cyc_q[$], done_cyc_q[$];
  logic [DATA_W-1:0] in_dat_q[$], wr_dat_q[$];
  logic [DATA_W-1:0] exp_wr[$];  // stable results the filter emitted, in order

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

  always @(negedge clk) begin
    if (bus.mem_rd_en) begin rd_addr_q.push_back(int'(bus.mem_addr)); rd_cyc_q.push_back(cyc); end
    if (bus.iir_data_in_valid) begin in_cyc_q.push_back(cyc); in_dat_q.push_back(bus.iir_data_in); end
    if (bus.out_wr_en) begin
      wr_addr_q.push_back(int'(bus.out_wr_addr)); wr_cyc_q.push_back(cyc); wr_dat_q.push_back(bus.out_wr_data);
    end
    if (filter_done) done_cyc_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_addr_q.delete(); rd_cyc_q.delete(); in_cyc_q.delete(); in_dat_q.delete();
    wr_addr_q.delete(); wr_cyc_q.delete(); wr_dat_q.delete(); done_cyc_q.delete(); exp_wr.delete();
  endtask

  task automatic fill_mem();
    for (int k = 0; k < FRAME_LEN; k++) mem[k] = DATA_W'($urandom);
  endtask

  // Filter stand-in: LAT cycles after the first fed sample, emit n_total back-to-back results.
  task automatic emit(input int n_total, input int n_unstable);
    int guard;
    logic [DATA_W-1:0] d;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!bus.iir_data_in_valid && guard < 400);
    if (!bus.iir_data_in_valid) begin emit_busy = 1'b0; return; end
    repeat (LAT) @(negedge clk);
    for (int i = 0; i < n_total; i++) begin
      d = (i < FRAME_LEN) ? mem[i] : DATA_W'($urandom);
      bus.iir_data_out       = d;
      bus.iir_data_out_valid = 1'b1;
      bus.iir_stable         = (i >= n_unstable);
      if (i >= n_unstable) exp_wr.push_back(d);
      @(negedge clk);
    end
    bus.iir_data_out_valid = 1'b0;
    bus.iir_stable         = 1'b1;
    bus.iir_data_out       = DATA_W'($urandom);
    emit_busy = 1'b0;
  endtask

  task automatic run_frame(input int en_delay, input int n_total, input int n_unstable, output int wait_bad);
    int guard;
    clear_logs();
    fill_mem();
    bus.iir_pipeline_en = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    emit_busy = 1'b1;
    fork emit(n_total, n_unstable); join_none
    wait_bad = 0;
    for (int k = 0; k < en_delay; k++) begin
      if (!busy || bus.mem_rd_en) wait_bad++;
      @(negedge clk);
    end
    bus.iir_pipeline_en = 1'b1;
    guard = 0;
    while (!filter_done && guard < 300) begin @(negedge clk); guard++; end
    repeat (20) @(negedge clk);
    bus.iir_pipeline_en = 1'b0;
    guard = 0;
    while (emit_busy && guard < 100) begin @(negedge clk); guard++; end
  endtask

  // Reference: a full contiguous read of 0..FRAME_LEN-1, inputs echo memory, and the first
  // FRAME_LEN stable results get written in order; fewer than that means a timeout.
  task automatic check_frame(input string tag);
    int n_exp, bad;
    logic exp_to;
    exp_to = (exp_wr.size() < FRAME_LEN);
    n_exp  = exp_to ? exp_wr.size() : FRAME_LEN;
    check({tag, "_rd_count"}, rd_addr_q.size(), FRAME_LEN);
    bad = 0;
    for (int k = 0; k < rd_addr_q.size(); k++)
      if (rd_addr_q[k] != k || rd_cyc_q[k] != rd_cyc_q[0] + k) bad++;
    check({tag, "_rd_seq_errs"}, bad, 0);
    check({tag, "_in_count"}, in_cyc_q.size(), FRAME_LEN);
    bad = 0;
    for (int k = 0; k < in_cyc_q.size(); k++)
      if (k >= rd_cyc_q.size() || k >= FRAME_LEN || in_cyc_q[k] != rd_cyc_q[k] + 1 || in_dat_q[k] !== mem[k]) bad++;
    check({tag, "_in_seq_errs"}, bad, 0);
    check({tag, "_wr_count"}, wr_addr_q.size(), n_exp);
    bad = 0;
    for (int k = 0; k < wr_addr_q.size(); k++)
      if (k >= exp_wr.size() || wr_addr_q[k] != k || wr_dat_q[k] !== exp_wr[k]) bad++;
    check({tag, "_wr_seq_errs"}, bad, 0);
    check({tag, "_done_pulses"}, done_cyc_q.size(), 1);
    check({tag, "_timeout_err"}, timeout_err, exp_to);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_rd_en"}, bus.mem_rd_en, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_iir_data_in"}, bus.iir_data_in, 0);
    check({tag, "_iir_data_in_valid"}, bus.iir_data_in_valid, 0);
    check({tag, "_out_wr_en"}, bus.out_wr_en, 0);
    check({tag, "_out_wr_addr"}, bus.out_wr_addr, 0);
    check({tag, "_out_wr_data"}, bus.out_wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_filter_done"}, filter_done, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    int bad, guard, gap, nu, nt;
    bus.iir_pipeline_en    = 1'b0;
    bus.iir_data_out       = '0;
    bus.iir_data_out_valid = 1'b0;
    bus.iir_stable         = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    run_frame(3, 8, 0, bad);
    check("nom_wait_errs", bad, 0);
    check_frame("nom");

    run_frame(50, 8, 0, bad);
    check("late_wait_errs", bad, 0);
    check_frame("late");

    run_frame(3, 6, 0, bad);
    check_frame("miss");
    gap = -1;
    if (done_cyc_q.size() == 1 && wr_cyc_q.size() == 6) gap = done_cyc_q[0] - wr_cyc_q[5];
    check("miss_done_gap", gap, TIMEOUT);

    run_frame(3, 14, 2, bad);
    check_frame("unstable");

    // Abort while address 4 is being issued; late filter results must be dropped.
    clear_logs();
    fill_mem();
    start = 1'b1; @(negedge clk); start = 1'b0;
    emit_busy = 1'b1;
    fork emit(8, 0); join_none
    repeat (2) @(negedge clk);
    bus.iir_pipeline_en = 1'b1;
    guard = 0;
    while (!(bus.mem_rd_en && bus.mem_addr == 3'd4) && guard < 100) begin @(negedge clk); guard++; end
    check("abort_reached_addr4", guard < 100, 1);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_mem_rd_en", bus.mem_rd_en, 0);
    check("abort_in_valid", bus.iir_data_in_valid, 0);
    check("abort_wr_en", bus.out_wr_en, 0);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy || bus.mem_rd_en || bus.iir_data_in_valid || bus.out_wr_en || filter_done) bad++;
    end
    check("abort_quiet_cycles", bad, 0);
    check("abort_done_pulses", done_cyc_q.size(), 0);
    bus.iir_pipeline_en = 1'b0;
    guard = 0;
    while (emit_busy && guard < 100) begin @(negedge clk); guard++; end

    run_frame(3, 8, 0, bad);
    check_frame("post_abort");

    for (int r = 0; r < 3; r++) begin
      nu = $urandom_range(0, 2);
      nt = nu + FRAME_LEN + $urandom_range(0, 3);
      run_frame($urandom_range(1, 6), nt, nu, bad);
      check("rand_wait_errs", bad, 0);
      check_frame("rand");
    end

    // Reset in DRAIN with start raised alongside it.
    clear_logs();
    fill_mem();
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    bus.iir_pipeline_en = 1'b1;
    guard = 0;
    while (!(bus.mem_rd_en && bus.mem_addr == 3'd7) && guard < 100) begin @(negedge clk); guard++; end
    @(negedge clk); @(negedge clk);
    check("drain_busy", busy, 1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    bus.iir_pipeline_en = 1'b0;
    check_quiet("rst_drain");
    @(negedge clk);
    check_quiet("rst_after");

    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_quiet("start_abort");
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || bus.mem_rd_en) bad++;
    end
    check("start_abort_idle_cycles", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iir_stream_ctrl.md
IIR_STREAM_CTRL -- requirements
Module: iir_stream_ctrl

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 24, setting the Q2.22 sample width.
REQ-002 The block SHALL have parameter ADDR_W, default 11, setting the sample address width.
REQ-003 The block SHALL have parameter FRAME_LEN, default 2048, giving the samples per frame; it SHALL be no more than 2**ADDR_W.
REQ-004 The block SHALL have parameter TIMEOUT, default 256, giving the idle cycles allowed between outputs in DRAIN.

Interface
REQ-005 The block SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have these control ports:
- start  in  1  frame request pulse.
- abort  in  1  cancel the frame.
REQ-007 The block SHALL have these sample-memory ports:
- mem_rd_en  out  1  read strobe.
- mem_addr  out  ADDR_W  read address.
- mem_rd_data  in  DATA_W  read data, valid 1 cycle after mem_rd_en.
REQ-008 The block SHALL have these filter-side ports:
- iir_data_in  out  DATA_W  sample to the filter.
- iir_data_in_valid  out  1  sample valid.
- iir_pipeline_en  in  1  filter pipeline ready.
- iir_data_out  in  DATA_W  filter result.
- iir_data_out_valid  in  1  result valid.
- iir_stable  in  1  filter settled.
REQ-009 The block SHALL have these result-write ports:
- out_wr_en  out  1  result write strobe.
- out_wr_addr  out  ADDR_W  result address.
- out_wr_data  out  DATA_W  result data.
REQ-010 The block SHALL have these status ports:
- busy  out  1  frame in progress.
- filter_done  out  1  one-cycle completion pulse.
- timeout_err  out  1  sticky timeout flag.

Function
REQ-011 The FSM SHALL have the states IDLE, WAIT_EN, FEED, DRAIN and DONE.
REQ-012 In IDLE, start=1 SHALL move the FSM to WAIT_EN, clear timeout_err and clear both counters; start SHALL be ignored in every other state.
REQ-013 In WAIT_EN, iir_pipeline_en=1 SHALL move the FSM to FEED; the FSM SHALL wait in WAIT_EN indefinitely otherwise.
REQ-014 In FEED, mem_rd_en SHALL be 1 every cycle with mem_addr=rd_cnt, and rd_cnt SHALL increment by one per cycle.
REQ-015 On the cycle that issues address FRAME_LEN-1, the FSM SHALL move to DRAIN.
REQ-016 iir_data_in_valid SHALL equal mem_rd_en delayed 1 cycle, and iir_data_in SHALL equal mem_rd_data on that cycle.
REQ-017 iir_data_in_valid SHALL therefore be high for exactly FRAME_LEN consecutive cycles per frame, with no gaps.
REQ-018 Output capture SHALL happen only in FEED or DRAIN, only when iir_data_out_valid=1 and iir_stable=1, and only while out_cnt<FRAME_LEN.
REQ-019 On a capture, the block SHALL register out_wr_en=1, out_wr_addr=out_cnt and out_wr_data=iir_data_out, visible on the next cycle, and SHALL increment out_cnt.
REQ-020 Valid outputs arriving in IDLE, WAIT_EN or DONE, or with iir_stable=0, SHALL be dropped and SHALL NOT be counted.
REQ-021 In DRAIN, when out_cnt reaches FRAME_LEN (including on a capture), the FSM SHALL move to DONE.
REQ-022 In DRAIN, an idle counter SHALL reset on each capture; when it reaches TIMEOUT, the block SHALL set timeout_err=1 and move to DONE.
REQ-023 DONE SHALL last exactly 1 cycle with filter_done=1, then return to IDLE.
REQ-024 busy SHALL be 1 in WAIT_EN, FEED and DRAIN, and 0 in IDLE and DONE.
REQ-025 abort=1 in any state SHALL force IDLE on the next edge.
REQ-026 On abort, mem_rd_en, iir_data_in_valid and out_wr_en SHALL be 0 from the next cycle, and filter_done SHALL NOT pulse.
REQ-027 abort SHALL take priority over start, over completion and over timeout when they occur in the same cycle.
REQ-028 The address counters SHALL be ADDR_W+1 bits wide so that FRAME_LEN=2**ADDR_W does not wrap.
REQ-029 mem_addr and out_wr_addr SHALL be the low ADDR_W bits of their counters.
REQ-030 Data SHALL pass through bit-exact, with no arithmetic applied to samples.

Reset
REQ-031 With rst=1 on a clock edge, the FSM SHALL go to IDLE and all counters SHALL clear.
REQ-032 In reset, every output SHALL be 0: mem_rd_en, mem_addr, iir_data_in, iir_data_in_valid, out_wr_en, out_wr_addr, out_wr_data, busy, filter_done and timeout_err.
REQ-033 rst SHALL override abort and start.
REQ-034 rst asserted mid-frame SHALL leave no residual strobe on the following cycle.

Verification
REQ-035 The bench SHALL cover these directed scenarios (FRAME_LEN=8, TIMEOUT=16):
- Nominal: start, pipeline_en high 3 cycles later, filter echoes input after 5 cycles -> 8 contiguous iir_data_in_valid, addresses 0..7, 8 out_wr_en at addresses 0..7, one filter_done pulse, timeout_err=0.
- Late enable: pipeline_en held low 50 cycles -> no mem_rd_en during WAIT_EN, busy=1, then the nominal sequence.
- Missing outputs: filter emits only 6 valids -> filter_done 16 cycles after the 6th capture, timeout_err=1, out_wr_en count=6.
- Unstable or extra outputs: iir_stable=0 for the first 2 valids, then 12 valids -> exactly 8 writes, extra valids ignored.
- Abort mid-FEED at rd_cnt=4 -> next cycle busy=0, no strobes, no filter_done; a following start runs a clean nominal frame.
- Reset at DRAIN, and start with abort in the same cycle -> all outputs 0 next cycle, FSM stays IDLE.
